// File: rtl/fetch_stage.sv
// LEGv8 instruction-fetch stage with IF/ID pipeline register.
// Keeps one outstanding request on a latency-tolerant imem port.
// A one-entry skid buffer catches a response that arrives while decode is stalled.
// Branch redirects flush IF/ID and the skid, and any in-flight response is dropped.
module fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    output logic        if_id_valid,
    output logic [63:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic [10:0] if_id_opcode
);

    localparam int unsigned XLEN  = 64;
    localparam int unsigned ILEN  = 32;
    localparam int unsigned OPW   = 11;
    localparam int unsigned STEP  = 4;

    // REQ: may issue; WAIT: response kept; DRAIN: response dropped
    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic              skid_valid, skid_valid_d;
    logic [XLEN-1:0]   skid_pc, skid_pc_d;
    logic [ILEN-1:0]   skid_instr, skid_instr_d;
    logic              valid_d;
    logic [XLEN-1:0]   id_pc_d;
    logic [ILEN-1:0]   id_instr_d;
    logic              take_data;

    // Request is combinational so a redirect suppresses issue in the same cycle
    assign imem_req     = rst_n && (state_q == S_REQ) && !skid_valid && !branch_taken;
    assign imem_addr    = pc_q;
    assign if_id_opcode = if_id_instr[ILEN-1 -: OPW];

    // Next-state: redirect first, then fetch FSM, then IF/ID / skid movement
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fetch_pc_d   = fetch_pc_q;
        skid_valid_d = skid_valid;
        skid_pc_d    = skid_pc;
        skid_instr_d = skid_instr;
        valid_d      = if_id_valid;
        id_pc_d      = if_id_pc;
        id_instr_d   = if_id_instr;
        take_data    = 1'b0;

        if (branch_taken) begin
            valid_d      = 1'b0;
            skid_valid_d = 1'b0;
            pc_d         = branch_target;
            if (state_q != S_REQ && imem_rvalid) begin
                state_d = S_REQ;
            end else if (state_q == S_WAIT) begin
                state_d = S_DRAIN;
            end
        end else begin
            case (state_q)
                S_REQ: begin
                    if (imem_req && imem_gnt) begin
                        fetch_pc_d = pc_q;
                        pc_d       = pc_q + XLEN'(STEP);
                        state_d    = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        take_data = 1'b1;
                        state_d   = S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (imem_rvalid) begin
                        state_d = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase

            if (take_data) begin
                if (!if_id_valid || !stall) begin
                    valid_d    = 1'b1;
                    id_pc_d    = fetch_pc_q;
                    id_instr_d = imem_rdata;
                end else begin
                    skid_valid_d = 1'b1;
                    skid_pc_d    = fetch_pc_q;
                    skid_instr_d = imem_rdata;
                end
            end else if (!if_id_valid || !stall) begin
                if (skid_valid) begin
                    valid_d      = 1'b1;
                    id_pc_d      = skid_pc;
                    id_instr_d   = skid_instr;
                    skid_valid_d = 1'b0;
                end else begin
                    valid_d = 1'b0;
                end
            end
        end
    end

    // State, PC, skid and IF/ID registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            fetch_pc_q  <= '0;
            skid_valid  <= 1'b0;
            skid_pc     <= '0;
            skid_instr  <= '0;
            if_id_valid <= 1'b0;
            if_id_pc    <= '0;
            if_id_instr <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            fetch_pc_q  <= fetch_pc_d;
            skid_valid  <= skid_valid_d;
            skid_pc     <= skid_pc_d;
            skid_instr  <= skid_instr_d;
            if_id_valid <= valid_d;
            if_id_pc    <= id_pc_d;
            if_id_instr <= id_instr_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then randomized traffic,
// checked against a program-order model of what decode should receive.
module tb_fetch_stage;

    localparam logic [63:0] RST_PC  = 64'h0;
    localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [63:0] branch_target = 64'h0;
    logic        if_id_valid;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic [10:0] if_id_opcode;

    logic        w_req;
    logic [63:0] w_addr;
    logic        w_rvalid = 1'b0;
    logic        w_valid;
    logic [63:0] w_pc;
    logic [31:0] w_instr;
    logic [10:0] w_opcode;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
        .if_id_instr(if_id_instr), .if_id_opcode(if_id_opcode)
    );

    fetch_stage #(.RESET_PC(WRAP_PC)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(1'b1),
        .imem_rvalid(w_rvalid), .imem_rdata(32'h8B02_0020),
        .stall(1'b0), .branch_taken(1'b0), .branch_target(64'h0),
        .if_id_valid(w_valid), .if_id_pc(w_pc),
        .if_id_instr(w_instr), .if_id_opcode(w_opcode)
    );

    int total = 0;
    int bad   = 0;

    // memory model state
    bit          outstanding = 1'b0;
    int          cnt = 0;
    logic [63:0] paddr = 64'h0;
    bit          gnt_rand = 1'b0;
    int          lat_fixed = 1;

    // program-order reference model
    logic [63:0] exp_fetch = RST_PC;
    logic [63:0] exp_pc = RST_PC;
    bit          prev_hold = 1'b0;
    bit          prev_branch = 1'b0;
    logic [63:0] prev_pc = 64'h0;
    logic [31:0] prev_instr = 32'h0;

    bit          w_acc_prev = 1'b0;
    logic [63:0] w_addrs[$];

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        if (a == 64'h0) return 32'h8B02_0020;
        if (a == 64'h4) return 32'hF840_03E1;
        return 32'(a ^ (a >> 32)) ^ 32'h1357_2468;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs at negedge, then check and update the model
    task automatic cycle(input bit rst_v, input bit stall_v, input bit br_v, input logic [63:0] tgt);
        logic [31:0] ei;
        @(negedge clk);
        rst_n         = rst_v;
        stall         = stall_v;
        branch_taken  = br_v;
        branch_target = tgt;
        imem_gnt      = gnt_rand ? ($urandom_range(0, 9) < 7) : 1'b1;
        imem_rvalid   = 1'b0;
        imem_rdata    = 32'hDEAD_BEEF;
        if (!rst_v) outstanding = 1'b0;
        if (outstanding) begin
            cnt--;
            if (cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = instr_of(paddr);
                outstanding = 1'b0;
            end
        end
        w_rvalid = w_acc_prev && rst_v;
        #1;
        w_acc_prev = w_req;
        if (w_req && w_addrs.size() < 4) w_addrs.push_back(w_addr);

        if (!rst_v) begin
            chk("req_in_reset", 64'(imem_req), 64'h0);
            exp_fetch   = RST_PC;
            exp_pc      = RST_PC;
            prev_hold   = 1'b0;
            prev_branch = 1'b0;
            return;
        end

        chk("skid_full_with_rvalid", 64'(dut.skid_valid && imem_rvalid), 64'h0);
        if (prev_branch) chk("flush_valid", 64'(if_id_valid), 64'h0);
        if (prev_hold) begin
            chk("hold_valid", 64'(if_id_valid), 64'h1);
            chk("hold_pc", if_id_pc, prev_pc);
            chk("hold_instr", 64'(if_id_instr), 64'(prev_instr));
        end
        if (br_v) chk("req_on_branch", 64'(imem_req), 64'h0);
        if (imem_req && imem_gnt) begin
            chk("one_outstanding", 64'(outstanding), 64'h0);
            chk("fetch_addr", imem_addr, exp_fetch);
            exp_fetch   = exp_fetch + 64'd4;
            outstanding = 1'b1;
            cnt         = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 3));
            paddr       = imem_addr;
        end
        if (if_id_valid && !stall_v && !br_v) begin
            ei = instr_of(exp_pc);
            chk("consume_pc", if_id_pc, exp_pc);
            chk("consume_instr", 64'(if_id_instr), 64'(ei));
            chk("consume_opcode", 64'(if_id_opcode), 64'(ei[31:21]));
            exp_pc = exp_pc + 64'd4;
        end
        if (br_v) begin
            exp_fetch = tgt;
            exp_pc    = tgt;
        end
        prev_hold   = if_id_valid && stall_v && !br_v;
        prev_pc     = if_id_pc;
        prev_instr  = if_id_instr;
        prev_branch = br_v;
    endtask

    initial begin
        logic [63:0] tgt;
        bit          s, b;

        // reset state
        gnt_rand  = 1'b0;
        lat_fixed = 1;
        cycle(0, 0, 0, 64'h0);
        cycle(0, 0, 0, 64'h0);
        chk("rst_valid", 64'(if_id_valid), 64'h0);
        chk("rst_pc", if_id_pc, 64'h0);
        chk("rst_instr", 64'(if_id_instr), 64'h0);
        chk("rst_opcode", 64'(if_id_opcode), 64'h0);
        chk("rst_addr", imem_addr, RST_PC);

        // ADD then LDUR, one instruction every 2 cycles
        cycle(1, 0, 0, 64'h0);                                   // c0
        chk("c0_req", 64'(imem_req), 64'h1);
        chk("c0_addr", imem_addr, 64'h0);
        cycle(1, 0, 0, 64'h0);                                   // c1
        cycle(1, 0, 0, 64'h0);                                   // c2
        chk("c2_valid", 64'(if_id_valid), 64'h1);
        chk("c2_pc", if_id_pc, 64'h0);
        chk("c2_opcode", 64'(if_id_opcode), 64'h458);
        cycle(1, 0, 0, 64'h0);                                   // c3
        chk("c3_bubble", 64'(if_id_valid), 64'h0);
        cycle(1, 0, 0, 64'h0);                                   // c4
        chk("c4_valid", 64'(if_id_valid), 64'h1);
        chk("c4_pc", if_id_pc, 64'h4);
        chk("c4_opcode", 64'(if_id_opcode), 64'h7C2);
        cycle(1, 0, 0, 64'h0);                                   // c5

        // stall 5 cycles while pc 12 arrives into the skid
        cycle(1, 1, 0, 64'h0);                                   // c6
        cycle(1, 1, 0, 64'h0);                                   // c7
        cycle(1, 1, 0, 64'h0);                                   // c8
        chk("stall_req", 64'(imem_req), 64'h0);
        chk("stall_pc", if_id_pc, 64'h8);
        cycle(1, 1, 0, 64'h0);                                   // c9
        chk("skid_valid", 64'(dut.skid_valid), 64'h1);
        chk("skid_pc", dut.skid_pc, 64'hC);
        cycle(1, 1, 0, 64'h0);                                   // c10
        cycle(1, 0, 0, 64'h0);                                   // c11
        chk("release_req", 64'(imem_req), 64'h0);
        lat_fixed = 3;
        cycle(1, 0, 0, 64'h0);                                   // c12
        chk("skid_out_pc", if_id_pc, 64'hC);
        chk("skid_out_valid", 64'(if_id_valid), 64'h1);
        chk("next_addr", imem_addr, 64'h10);
        chk("next_req", 64'(imem_req), 64'h1);

        // redirect while pc 16 is outstanding with latency 3
        cycle(1, 0, 1, 64'h100);                                 // c13
        cycle(1, 0, 0, 64'h0);                                   // c14
        chk("drain_req", 64'(imem_req), 64'h0);
        chk("drain_valid", 64'(if_id_valid), 64'h0);
        cycle(1, 0, 0, 64'h0);                                   // c15
        chk("drain_rvalid_req", 64'(imem_req), 64'h0);
        lat_fixed = 1;
        cycle(1, 0, 0, 64'h0);                                   // c16
        chk("target_req", 64'(imem_req), 64'h1);
        chk("target_addr", imem_addr, 64'h100);
        chk("target_no_stale", 64'(if_id_valid), 64'h0);
        cycle(1, 0, 0, 64'h0);                                   // c17
        cycle(1, 0, 0, 64'h0);                                   // c18
        chk("target_pc", if_id_pc, 64'h100);

        // redirect in the same cycle as rvalid
        cycle(1, 0, 1, 64'h200);                                 // c19
        cycle(1, 0, 0, 64'h0);                                   // c20
        chk("same_cyc_req", 64'(imem_req), 64'h1);
        chk("same_cyc_addr", imem_addr, 64'h200);
        chk("same_cyc_valid", 64'(if_id_valid), 64'h0);
        cycle(1, 0, 0, 64'h0);                                   // c21

        // redirect under stall with skid full
        cycle(1, 1, 0, 64'h0);                                   // c22
        chk("pre_skid_pc", if_id_pc, 64'h200);
        cycle(1, 1, 0, 64'h0);                                   // c23
        cycle(1, 1, 1, 64'h300);                                 // c24
        chk("skid_before_br", 64'(dut.skid_valid), 64'h1);
        cycle(1, 0, 0, 64'h0);                                   // c25
        chk("br_skid_cleared", 64'(dut.skid_valid), 64'h0);
        chk("br_valid_cleared", 64'(if_id_valid), 64'h0);
        chk("br_resume_req", 64'(imem_req), 64'h1);
        chk("br_resume_addr", imem_addr, 64'h300);

        // PC wrap on the second instance
        chk("wrap_count", 64'(w_addrs.size() >= 2), 64'h1);
        if (w_addrs.size() >= 2) begin
            chk("wrap_first", w_addrs[0], WRAP_PC);
            chk("wrap_second", w_addrs[1], 64'h0);
        end

        // mid-operation reset, then randomized traffic
        cycle(0, 0, 0, 64'h0);
        cycle(0, 0, 0, 64'h0);
        gnt_rand  = 1'b1;
        lat_fixed = 0;
        for (int i = 0; i < 3000; i++) begin
            s   = ($urandom_range(0, 9) < 3);
            b   = ($urandom_range(0, 19) == 0);
            tgt = {$urandom, $urandom} & ~64'h3;
            cycle(1, s, b, tgt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage plus IF/ID pipeline register for the LEGv8 pipeline. It drives a latency-tolerant instruction-memory request/response port and holds one outstanding fetch. Stall and branch-redirect are handled here. The decoded field `if_id_opcode` (instr[31:21]) feeds the main control decoder directly.

## Interface
- `RESET_PC`, default 64'h0: PC loaded on reset.
- `clk` input 1: single clock, all state on rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `imem_req` output 1: fetch request valid.
- `imem_addr` output 64: fetch address; equals `pc_q`.
- `imem_gnt` input 1: memory accepts request this cycle; transfer when `imem_req && imem_gnt`.
- `imem_rvalid` input 1: one-cycle response pulse.
- `imem_rdata` input 32: instruction word, valid with `imem_rvalid`.
- `stall` input 1: decode cannot accept; hold IF/ID.
- `branch_taken` input 1: redirect, resolved CBZ taken; flush IF/ID.
- `branch_target` input 64: redirect PC.
- `if_id_valid` output 1: IF/ID holds a live instruction.
- `if_id_pc` output 64: PC of the IF/ID instruction.
- `if_id_instr` output 32: IF/ID instruction word.
- `if_id_opcode` output 11: `if_id_instr[31:21]`, combinational from the register.

## Operation
- Memory contract:
  - At most one outstanding request.
  - Exactly one `imem_rvalid` per accepted request, at least 1 cycle after accept.
  - The address is sampled only at accept.
- State registers: `pc_q`, `fetch_pc_q` (address of the outstanding request), FSM state, skid entry (`skid_valid`, `skid_pc`, `skid_instr`), IF/ID register.
- FSM states:
  - REQ: may issue.
  - WAIT: request outstanding; response will be kept.
  - DRAIN: request outstanding; response will be discarded.
- `imem_req = (state==REQ) && !skid_valid && !branch_taken`.
- REQ, on accept: `fetch_pc_q<=pc_q`, `pc_q<=pc_q+4` (64-bit, wraps modulo 2^64), go to WAIT.
- WAIT, on `imem_rvalid` with no redirect:
  - If `!if_id_valid || !stall`: load IF/ID with {fetch_pc_q, imem_rdata}, valid=1.
  - Otherwise: write the skid entry.
  - Go to REQ in both cases.
- DRAIN, on `imem_rvalid`: discard the data, go to REQ.
- `branch_taken` has the highest priority and overrides stall:
  - IF/ID valid<=0, skid_valid<=0, `pc_q<=branch_target`.
  - WAIT without `rvalid` goes to DRAIN.
  - WAIT with `rvalid` in the same cycle discards the data and goes to REQ.
  - DRAIN stays DRAIN until `rvalid`.
  - REQ stays REQ; no request is issued that cycle.
- `stall && if_id_valid`: IF/ID holds all fields.
- `!stall`, no incoming data:
  - If `skid_valid`: move skid into IF/ID, skid_valid<=0.
  - Else: if_id_valid<=0 (bubble).
- `skid_valid && imem_rvalid` cannot occur, because no request is issued while skid is full. A bench assertion must flag it.
- `stall` while IF/ID is empty has no effect; data loads directly.

## Timing
- Reset (rst_n=0 at an edge):
  - `pc_q=RESET_PC`, state=REQ, all valids 0.
  - `if_id_pc`, `if_id_instr` = 0, so `if_id_opcode`=0.
  - `imem_req` is 0 while rst_n=0, then 1 in the first cycle after release.
- Reset mid-operation: the in-flight response is ignored if the memory is reset together with this stage. The stage restarts at `RESET_PC`.
- Throughput with gnt=1 and 1-cycle response latency:
  - Accept at cycle N, rvalid at N+1, IF/ID valid at N+2.
  - Next request issues at N+2, so one instruction every 2 cycles.
- Redirect latency: target request issues in the cycle after `branch_taken` if no request is outstanding. Otherwise it issues in the cycle after the drained `rvalid`.
- All outputs except `imem_req` and `if_id_opcode` are registered.

## Test plan
- Reset, RESET_PC=0, gnt=1, latency 1, rdata=32'h8B020020 (ADD) then 32'hF84003E1 (LDUR):
  - IF/ID pc 0 with opcode 11'h458, then pc 4 with opcode 11'h7C2.
  - if_id_valid pulses every 2 cycles.
- Stall held for 5 cycles while a response arrives:
  - IF/ID stays at pc 8; skid captures pc 12; `imem_req`=0.
  - On stall release, pc 12 enters IF/ID and the next request is for addr 16.
- `branch_taken`=1 with target 64'h100 while a request for pc 16 is outstanding with latency 3:
  - IF/ID valid drops; state goes to DRAIN; the pc 16 data is never seen.
  - Next `imem_addr`=64'h100.
- `branch_taken` in the same cycle as `imem_rvalid`: data discarded, request to target issued next cycle.
- `branch_taken` plus `stall` with skid full: IF/ID and skid both cleared, fetch resumes at target.
- RESET_PC=64'hFFFFFFFFFFFFFFFC: second fetch address is 0 (wrap).
